// File: rtl/exec_unit.sv
// exec_unit: execute stage (condition check, ALU, {N,Z,V} flags, registered writeback); EXEC_DIVIDER_EN adds DIV/MOD.
// Latency: one cycle for ALU ops, 33 for DIV/MOD. Backpressure: the output register holds until out_ready and in_ready drops.
module exec_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_kind,
  input  logic [2:0]  in_cond,
  input  logic [4:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_rd,
  output logic [31:0] out_result,
  output logic [2:0]  flags,
  output logic        illegal
);

  localparam logic [2:0] KIND_RRR = 3'd0;
  localparam logic [2:0] KIND_RRI = 3'd3;

  localparam logic [2:0] COND_AL = 3'd0;
  localparam logic [2:0] COND_EQ = 3'd1;
  localparam logic [2:0] COND_NE = 3'd2;
  localparam logic [2:0] COND_GT = 3'd3;
  localparam logic [2:0] COND_GE = 3'd4;
  localparam logic [2:0] COND_LT = 3'd5;
  localparam logic [2:0] COND_LE = 3'd6;
  localparam logic [2:0] COND_NV = 3'd7;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_MUL = 5'd2;
  localparam logic [4:0] OP_AND = 5'd3;
  localparam logic [4:0] OP_OR  = 5'd4;
  localparam logic [4:0] OP_XOR = 5'd5;
  localparam logic [4:0] OP_SHL = 5'd6;
  localparam logic [4:0] OP_ASL = 5'd7;
  localparam logic [4:0] OP_SHR = 5'd8;
  localparam logic [4:0] OP_ASR = 5'd9;
  localparam logic [4:0] OP_ROL = 5'd10;
  localparam logic [4:0] OP_ROR = 5'd11;
  localparam logic [4:0] OP_NOT = 5'd12;
  localparam logic [4:0] OP_NEG = 5'd13;
  localparam logic [4:0] OP_DIV = 5'd14;
  localparam logic [4:0] OP_MOD = 5'd15;
  localparam logic [4:0] OP_CMP = 5'd16;

  logic [2:0]  flags_q, flags_d;
  logic        out_valid_q, out_valid_d;
  logic [4:0]  out_rd_q, out_rd_d;
  logic [31:0] out_result_q, out_result_d;
  logic        illegal_q, illegal_d;

  logic        flag_n, flag_z, flag_v;
  logic        transfer, cond_ok, kind_ok, op_is_div, op_ok, inst_illegal, inst_exec;
  logic [4:0]  shamt;
  logic [5:0]  rot_inv;
  logic [31:0] diff, mul_lo, alu_res;
  logic        cmp_v;

  assign {flag_n, flag_z, flag_v} = flags_q;

  assign transfer     = in_valid && in_ready;
  assign kind_ok      = (in_kind == KIND_RRR) || (in_kind == KIND_RRI);
  assign op_is_div    = (in_op == OP_DIV) || (in_op == OP_MOD);
`ifdef EXEC_DIVIDER_EN
  assign op_ok        = (in_op <= OP_CMP);
`else
  assign op_ok        = (in_op <= OP_CMP) && !op_is_div;
`endif
  assign inst_illegal = !(kind_ok && op_ok);
  assign inst_exec    = transfer && !inst_illegal && cond_ok;

  always_comb begin
    cond_ok = 1'b0;
    case (in_cond)
      COND_AL: cond_ok = 1'b1;
      COND_EQ: cond_ok = flag_z;
      COND_NE: cond_ok = !flag_z;
      COND_GT: cond_ok = !flag_z && (flag_n == flag_v);
      COND_GE: cond_ok = (flag_n == flag_v);
      COND_LT: cond_ok = (flag_n != flag_v);
      COND_LE: cond_ok = flag_z || (flag_n != flag_v);
      COND_NV: cond_ok = 1'b0;
      default: cond_ok = 1'b0;
    endcase
  end

  assign shamt   = in_b[4:0];
  // A zero rotate makes the complementary shift 32, which yields 0 and leaves in_a intact.
  assign rot_inv = 6'd32 - {1'b0, shamt};
  assign diff    = in_a - in_b;
  assign mul_lo  = in_a * in_b;
  assign cmp_v   = (in_a[31] != in_b[31]) && (diff[31] != in_a[31]);

  always_comb begin
    alu_res = 32'd0;
    case (in_op)
      OP_ADD:         alu_res = in_a + in_b;
      OP_SUB:         alu_res = diff;
      OP_MUL:         alu_res = mul_lo;
      OP_AND:         alu_res = in_a & in_b;
      OP_OR:          alu_res = in_a | in_b;
      OP_XOR:         alu_res = in_a ^ in_b;
      OP_SHL, OP_ASL: alu_res = in_a << shamt;
      OP_SHR:         alu_res = in_a >> shamt;
      OP_ASR:         alu_res = $unsigned($signed(in_a) >>> shamt);
      OP_ROL:         alu_res = (in_a << shamt) | (in_a >> rot_inv);
      OP_ROR:         alu_res = (in_a >> shamt) | (in_a << rot_inv);
      OP_NOT:         alu_res = ~in_a;
      OP_NEG:         alu_res = 32'd0 - in_a;
      default:        alu_res = 32'd0;
    endcase
  end

`ifdef EXEC_DIVIDER_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic        is_mod_q, is_mod_d;
  logic [4:0]  div_rd_q, div_rd_d;
  logic [32:0] rem_shift;
  logic        rem_ge;

  // quo_q starts as the dividend and shifts quotient bits in from the bottom as dividend bits leave the top.
  assign rem_shift = {rem_q, quo_q[31]};
  assign rem_ge    = (rem_shift >= {1'b0, dvsr_q});
  assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
`else
  assign in_ready  = !out_valid_q || out_ready;
`endif

  always_comb begin
    flags_d      = flags_q;
    out_valid_d  = out_valid_q;
    out_rd_d     = out_rd_q;
    out_result_d = out_result_q;
    illegal_d    = transfer && inst_illegal;
`ifdef EXEC_DIVIDER_EN
    state_d      = state_q;
    cnt_d        = cnt_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    dvsr_d       = dvsr_q;
    is_mod_d     = is_mod_q;
    div_rd_d     = div_rd_q;
`endif
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (inst_exec) begin
      if (in_op == OP_CMP) begin
        flags_d = {diff[31], (diff == 32'd0), cmp_v};
`ifdef EXEC_DIVIDER_EN
      end else if (op_is_div) begin
        state_d  = S_DIV;
        cnt_d    = 5'd31;
        rem_d    = 32'd0;
        quo_d    = in_a;
        dvsr_d   = in_b;
        is_mod_d = (in_op == OP_MOD);
        div_rd_d = in_rd;
`endif
      end else begin
        out_valid_d  = 1'b1;
        out_rd_d     = in_rd;
        out_result_d = alu_res;
      end
    end
`ifdef EXEC_DIVIDER_EN
    case (state_q)
      S_DIV: begin
        // Divide by zero always takes the subtract path: quotient all ones, remainder ends equal to the dividend.
        if (rem_ge) begin
          rem_d = rem_shift[31:0] - dvsr_q;
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = rem_shift[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        out_valid_d  = 1'b1;
        out_rd_d     = div_rd_q;
        out_result_d = is_mod_q ? rem_q : quo_q;
        state_d      = S_IDLE;
      end
      default: ;
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q      <= 3'b000;
      out_valid_q  <= 1'b0;
      out_rd_q     <= 5'd0;
      out_result_q <= 32'd0;
      illegal_q    <= 1'b0;
`ifdef EXEC_DIVIDER_EN
      state_q      <= S_IDLE;
      cnt_q        <= 5'd0;
      rem_q        <= 32'd0;
      quo_q        <= 32'd0;
      dvsr_q       <= 32'd0;
      is_mod_q     <= 1'b0;
      div_rd_q     <= 5'd0;
`endif
    end else begin
      flags_q      <= flags_d;
      out_valid_q  <= out_valid_d;
      out_rd_q     <= out_rd_d;
      out_result_q <= out_result_d;
      illegal_q    <= illegal_d;
`ifdef EXEC_DIVIDER_EN
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      dvsr_q       <= dvsr_d;
      is_mod_q     <= is_mod_d;
      div_rd_q     <= div_rd_d;
`endif
    end
  end

  assign out_valid  = out_valid_q;
  assign out_rd     = out_rd_q;
  assign out_result = out_result_q;
  assign flags      = flags_q;
  assign illegal    = illegal_q;

endmodule

// File: doc/exec_unit.md
# exec_unit

Execute stage of the core: consumes one decoded instruction per handshake (kind, condition, binary op, destination register, operands A/B), evaluates its condition against the architectural flags, computes the result and presents a registered writeback to the register file. All ops complete in a single cycle except DIV/MOD, which run on an optional 32-cycle iterative divider. CMP updates flags only.

## Interface
- Parameters: none; widths are fixed by the instruction format (32-bit data, 5-bit register index).
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage can accept this cycle
- in_kind  in  3  e_kind: RRR=0, MEMORY=1, MODEL=2, RRI=3, CUSTOM=4, INVALID=7
- in_cond  in  3  e_cond: AL,EQ,NE,GT,GE,LT,LE,NV = 0..7
- in_op  in  5  e_bin_op: ADD=0..CMP=16, INVALID=31
- in_rd  in  5  destination register
- in_a, in_b  in  32  operands (B already immediate-substituted for RRI)
- out_valid  out  1  writeback valid
- out_ready  in  1  register file accepts writeback
- out_rd  out  5  writeback register
- out_result  out  32  writeback data
- flags  out  3  {N,Z,V}, architectural flags
- illegal  out  1  one-cycle pulse: accepted instruction not executable here

## Operation
- Handshake: transfer when in_valid && in_ready; in_ready = (state==IDLE) && (!out_valid || out_ready). Inputs are sampled only on transfer.
- Kinds RRR and RRI execute; any other kind is consumed, illegal pulses, no writeback, flags unchanged.
- Condition, evaluated with flags at transfer: AL=1, NV=0, EQ=Z, NE=!Z, GT=!Z&&(N==V), GE=N==V, LT=N!=V, LE=Z||(N!=V). False condition: consumed silently, no writeback, no flag change, no illegal.
- Ops (32-bit, results truncated): ADD a+b; SUB a-b; MUL low 32 bits of a*b; AND/OR/XOR bitwise; SHL,ASL a<<b[4:0]; SHR logical right; ASR arithmetic right; ROL/ROR rotate by b[4:0]; NOT ~a; NEG 0-a.
- CMP: computes a-b; N=bit31, Z=(diff==0), V=signed overflow of a-b; no writeback.
- DIV/MOD unsigned, restoring algorithm, one quotient bit per cycle. Divide by zero: DIV gives 32'hFFFF_FFFF, MOD gives a; still 32 iteration cycles.
- Op codes 17..31: illegal, no writeback.
- States: IDLE, DIV (counter 31→0), DONE (load output register). IDLE→DIV on transfer of executing DIV/MOD; DIV→DONE when counter==0; DONE→IDLE next cycle.
- Output register holds until out_ready; no skid buffer.

## Timing
- Reset values: out_valid=0, out_rd=0, out_result=0, flags=3'b000, illegal=0, state IDLE, in_ready=1 the cycle after rst deasserts.
- Single-cycle op transferred at edge N: out_valid high after edge N; back-to-back issue at full rate while out_ready=1.
- CMP at edge N: flags visible after edge N; instruction transferred at N+1 conditions on new flags.
- DIV/MOD at edge N: 32 iteration edges N+1..N+32, DONE at N+33, out_valid after edge N+33; in_ready low throughout.
- out_valid && !out_ready: in_ready low; out_rd/out_result stable.
- illegal pulses the cycle after the transferring edge.
- rst asserted mid-divide: divide abandoned, no writeback, all state to reset values.

## Configuration
- EXEC_DIVIDER_EN defined: DIV/MOD execute as above.
- Undefined: divider and DIV/DONE states removed; DIV/MOD treated as invalid ops (illegal pulse, no writeback); in_ready depends only on output register.

## Test plan
- RRR ADD a=32'h7FFF_FFFF b=1 rd=3, cond AL -> out_rd=3, out_result=32'h8000_0000 one cycle later; flags unchanged.
- CMP a=5 b=5, then SUB a=9 b=4 cond EQ rd=1, then ADD cond NE -> flags Z=1; SUB writes 5 to r1; ADD produces no writeback.
- CMP a=32'h8000_0000 b=1 -> N=0,Z=0,V=1; following GE op suppressed, LT op writes back.
- DIV a=100 b=7 and MOD a=100 b=7 -> results 14 and 2, each 33 cycles after transfer; DIV by 0 -> 32'hFFFF_FFFF; rst at iteration 10 -> no writeback, flags 0.
- ASR a=32'hF000_0000 b=4 -> 32'hFF00_0000; ROR a=1 b=33 -> 32'h8000_0000; hold out_ready=0 for 5 cycles -> in_ready low, output stable.
- in_kind=MEMORY, then in_op=31 -> illegal pulses twice, no writeback; without EXEC_DIVIDER_EN, DIV -> illegal.
